pu_io_initiator: RTL and testbench
==================================

PU_IO_INITIATOR -- requirements
Module: pu_io_initiator

Interface
REQ-001 Parameter WIDTH_NBITS, default `PU_WIDTH_NBITS, data width of wdata and rdata.
REQ-002 Parameter TIMEOUT_CYC, default 255, number of WAIT cycles before a read is aborted; legal range 1..255.
REQ-003 Parameter WR_HOLD, default 2, number of cycles core_rdy stays low after a write issue; legal range 0..7.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 `RESET_SIG  input  1  reset, asynchronous and active-high.
REQ-006 core_req  input  1  core request valid.
REQ-007 core_wr  input  1  1 = write, 0 = read.
REQ-008 core_addr  input  `PU_ADDR_NBITS  target address, including memory-select MSBs.
REQ-009 core_fid  input  `FID_NBITS  flow id of the request.
REQ-010 core_wdata  input  WIDTH_NBITS  write data.
REQ-011 core_rdy  output  1  request accepted when core_req & core_rdy.
REQ-012 core_rvalid  output  1  one-cycle read-completion pulse.
REQ-013 core_rdata  output  WIDTH_NBITS  read data, valid with core_rvalid.
REQ-014 core_err  output  1  one-cycle timeout flag, coincident with core_rvalid.
REQ-015 io_req  output  1  one-cycle request strobe to the memory responder.
REQ-016 io_cmd  output  io_type  command (addr, wr, wdata, fid).
REQ-017 io_ack  input  1  responder read acknowledge.
REQ-018 io_ack_data  input  WIDTH_NBITS  read data, valid with io_ack.
REQ-019 spur_ack  output  1  one-cycle pulse on an io_ack received outside WAIT.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT, RESP, HOLD; registered state.
REQ-021 core_rdy = 1 only in IDLE; it is combinational from state.
- Accept in IDLE:
  - capture addr, wr, wdata and fid into the io_cmd register;
  - go to ISSUE.
REQ-022 In ISSUE, io_req = 1 for exactly one cycle.
- Next state:
  - WAIT if a read;
  - HOLD if a write and WR_HOLD > 0;
  - otherwise IDLE.
REQ-023 io_cmd is registered and stays stable from ISSUE until the next accept; writes are posted and never acknowledged.
REQ-024 HOLD counts WR_HOLD cycles, then returns to IDLE. This guarantees the responder's 1-deep per-PU input FIFO never overflows.
REQ-025 WAIT, 8-bit timeout counter:
- cleared on entry;
- incremented each cycle in WAIT without io_ack.
REQ-026 WAIT with io_ack:
- capture io_ack_data into core_rdata;
- go to RESP.
REQ-027 WAIT with counter == TIMEOUT_CYC-1 and no io_ack:
- go to RESP with core_rdata = 0 and an error flag set.
REQ-028 If io_ack arrives in the same cycle the timeout expires, the ack wins: no error, and the data is captured.
REQ-029 RESP, for one cycle:
- core_rvalid = 1;
- core_err = error flag;
- then IDLE, with the error flag cleared.
REQ-030 Read latency: accept cycle T, io_req at T+1, io_ack at T+1+N, core_rvalid at T+2+N; minimum accept-to-accept 4 cycles.
REQ-031 io_ack in any state other than WAIT is dropped; spur_ack pulses the following cycle.
REQ-032 core_rdata holds its last value outside RESP.

Reset
REQ-033 Asserting reset forces, asynchronously and at any state (including mid-WAIT):
- state = IDLE;
- io_req, core_rvalid, core_err, spur_ack = 0;
- io_cmd = 0, core_rdata = 0;
- counters and error flag = 0.
REQ-034 After reset deasserts, core_rdy = 1 on the first clock. A read aborted by reset is never reported.

Structure
REQ-035 io_type and `PU_ADDR_NBITS/`FID_NBITS/`PU_WIDTH_NBITS stay in type_package / defines.vh. The FSM state enum is local to the module.
REQ-036 The block is a single module with no sub-modules. The timeout and hold counters are inline.

Verification
REQ-037 Read, addr=0x10, fid=3; io_ack with 0xDEADBEEF 2 cycles after io_req:
- io_req a single cycle, with io_cmd.wr=0 and fid=3;
- core_rvalid=1 with rdata=0xDEADBEEF, core_err=0.
REQ-038 Two back-to-back writes, WR_HOLD=2:
- io_req pulses exactly 4 cycles apart;
- no io_ack is expected;
- core_rdy low for ISSUE+2 cycles.
REQ-039 Read with no io_ack, TIMEOUT_CYC=8:
- core_rvalid=1, core_err=1, rdata=0 exactly 9 cycles after io_req;
- a late io_ack afterwards gives spur_ack=1 and no core_rvalid.
REQ-040 io_ack with 0x55 in the timeout-expiry cycle, TIMEOUT_CYC=8: core_rvalid with rdata=0x55, core_err=0.
REQ-041 Reset asserted in WAIT:
- all outputs 0 immediately;
- core_rdy=1 on the first clock after release;
- an io_ack then gives spur_ack only.

Source files
------------

// File: rtl/pu_io_initiator_pkg.sv
// rtl/pu_io_initiator_pkg.sv - shared widths and the io command type for the PU io initiator
package pu_io_initiator_pkg;

    localparam int PU_ADDR_NBITS  = 16;
    localparam int FID_NBITS      = 4;
    localparam int PU_WIDTH_NBITS = 32;

    typedef struct packed {
        logic [PU_ADDR_NBITS-1:0]  addr;
        logic                      wr;
        logic [PU_WIDTH_NBITS-1:0] wdata;
        logic [FID_NBITS-1:0]      fid;
    } io_type;

endpackage

// File: rtl/pu_io_initiator.sv
// rtl/pu_io_initiator.sv - core-side request initiator with posted writes and timed-out reads
module pu_io_initiator
    import pu_io_initiator_pkg::*;
#(
    parameter int WIDTH_NBITS = PU_WIDTH_NBITS,
    parameter int TIMEOUT_CYC = 255,
    parameter int WR_HOLD     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     core_req,
    input  logic                     core_wr,
    input  logic [PU_ADDR_NBITS-1:0] core_addr,
    input  logic [FID_NBITS-1:0]     core_fid,
    input  logic [WIDTH_NBITS-1:0]   core_wdata,
    output logic                     core_rdy,
    output logic                     core_rvalid,
    output logic [WIDTH_NBITS-1:0]   core_rdata,
    output logic                     core_err,
    output logic                     io_req,
    output io_type                   io_cmd,
    input  logic                     io_ack,
    input  logic [WIDTH_NBITS-1:0]   io_ack_data,
    output logic                     spur_ack
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, HOLD} state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  to_cnt;
    logic [2:0]  hold_cnt;
    logic        err_flag;
    logic        to_expired;
    logic        hold_done;

    assign to_expired = (to_cnt == 8'(TIMEOUT_CYC - 1));
    assign hold_done  = (hold_cnt == 3'(WR_HOLD - 1));

    always_comb begin
        state_next  = state;
        core_rdy    = 1'b0;
        io_req      = 1'b0;
        core_rvalid = 1'b0;
        core_err    = 1'b0;
        case (state)
            IDLE: begin
                core_rdy = 1'b1;
                if (core_req) state_next = ISSUE;
            end
            ISSUE: begin
                io_req = 1'b1;
                if (!io_cmd.wr)       state_next = WAIT;
                else if (WR_HOLD > 0) state_next = HOLD;
                else                  state_next = IDLE;
            end
            WAIT: begin
                // An ack in the expiry cycle still completes the read normally.
                if (io_ack || to_expired) state_next = RESP;
            end
            RESP: begin
                core_rvalid = 1'b1;
                core_err    = err_flag;
                state_next  = IDLE;
            end
            HOLD: begin
                if (hold_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            io_cmd     <= '0;
            core_rdata <= '0;
            to_cnt     <= '0;
            hold_cnt   <= '0;
            err_flag   <= 1'b0;
            spur_ack   <= 1'b0;
        end else begin
            state    <= state_next;
            spur_ack <= io_ack && (state != WAIT);
            if (state == IDLE && core_req) begin
                io_cmd.addr  <= core_addr;
                io_cmd.wr    <= core_wr;
                io_cmd.wdata <= PU_WIDTH_NBITS'(core_wdata);
                io_cmd.fid   <= core_fid;
            end
            case (state)
                ISSUE: begin
                    to_cnt   <= '0;
                    hold_cnt <= '0;
                end
                WAIT: begin
                    if (io_ack) begin
                        core_rdata <= io_ack_data;
                        err_flag   <= 1'b0;
                    end else if (to_expired) begin
                        core_rdata <= '0;
                        err_flag   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                HOLD: hold_cnt <= hold_cnt + 3'd1;
                RESP: err_flag <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pu_io_initiator.sv
// tb/tb_pu_io_initiator.sv - self-checking bench for pu_io_initiator
module tb_pu_io_initiator;
    import pu_io_initiator_pkg::*;

    localparam int TO   = 8;
    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req;
    logic        core_wr;
    logic [15:0] core_addr;
    logic [3:0]  core_fid;
    logic [31:0] core_wdata;
    logic        core_rdy;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        core_err;
    logic        io_req;
    io_type      io_cmd;
    logic        io_ack;
    logic [31:0] io_ack_data;
    logic        spur_ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pu_io_initiator #(.WIDTH_NBITS(32), .TIMEOUT_CYC(TO), .WR_HOLD(HOLD)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_wr(core_wr), .core_addr(core_addr),
        .core_fid(core_fid), .core_wdata(core_wdata), .core_rdy(core_rdy),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
        .io_req(io_req), .io_cmd(io_cmd), .io_ack(io_ack),
        .io_ack_data(io_ack_data), .spur_ack(spur_ack)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [3:0]  fid;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] ack_data;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_spur;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic wr, input logic [15:0] addr, input logic [3:0] fid,
                          input logic [31:0] wdata);
        int n = 0;
        while (!core_rdy && n < 20) begin
            tick();
            n++;
        end
        check("accept_rdy", core_rdy, 1);
        core_req = 1'b1; core_wr = wr; core_addr = addr; core_fid = fid; core_wdata = wdata;
        tick();
        core_req = 1'b0; core_wdata = $urandom; core_addr = 16'($urandom);
        check("issue_io_req", io_req, 1);
        check("issue_wr", io_cmd.wr, wr);
        check("issue_addr", io_cmd.addr, addr);
        check("issue_fid", io_cmd.fid, fid);
        if (wr) check("issue_wdata", io_cmd.wdata, wdata);
    endtask

    task automatic run_read(input vec_t v);
        int lat = 0, nrv = 0, spur_at = 0, nreq = 0;
        logic gerr = 1'b0;
        logic [31:0] gdata = '0;
        accept(1'b0, v.addr, v.fid, 32'h0);
        for (int i = 1; i <= TO + v.delay + 3; i++) begin
            tick();
            if (core_rvalid) begin
                nrv++;
                if (lat == 0) begin lat = i; gerr = core_err; gdata = core_rdata; end
            end
            if (spur_ack && spur_at == 0) spur_at = i;
            if (io_req) nreq++;
            io_ack      = (i == v.delay);
            io_ack_data = (i == v.delay) ? v.ack_data : $urandom;
        end
        io_ack = 1'b0;
        check("rd_latency", 64'(lat), 64'(v.exp_lat));
        check("rd_rvalid_count", 64'(nrv), 1);
        check("rd_err", gerr, v.exp_err);
        check("rd_rdata", gdata, v.exp_rdata);
        check("rd_spur_at", 64'(spur_at), 64'(v.exp_spur));
        check("rd_extra_io_req", 64'(nreq), 0);
    endtask

    task automatic run_write(input vec_t v);
        int low = 1, nrv = 0;
        accept(1'b1, v.addr, v.fid, v.wdata);
        for (int i = 0; i < 12 && !core_rdy; i++) begin
            tick();
            if (core_rvalid) nrv++;
            if (!core_rdy) low++;
        end
        check("wr_rdy_low_cycles", 64'(low), 64'(1 + HOLD));
        check("wr_no_rvalid", 64'(nrv), 0);
    endtask

    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_err   = (v.delay > TO);
        r.exp_lat   = ((v.delay < TO) ? v.delay : TO) + 1;
        r.exp_rdata = r.exp_err ? 32'h0 : v.ack_data;
        r.exp_spur  = r.exp_err ? v.delay + 1 : 0;
        return r;
    endfunction

    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int req_at[$];
        logic [31:0] last_rdata;

        vecs[0] = '{1'b0, 16'h0010, 4'd3,  32'h0, 2,  32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF, 0};
        vecs[1] = '{1'b0, 16'h1234, 4'd7,  32'h0, 1,  32'h0BADF00D, 2, 1'b0, 32'h0BADF00D, 0};
        vecs[2] = '{1'b0, 16'hFFFF, 4'd15, 32'h0, 8,  32'h00000055, 9, 1'b0, 32'h00000055, 0};
        vecs[3] = '{1'b0, 16'h0002, 4'd0,  32'h0, 9,  32'h0000AAAA, 9, 1'b1, 32'h00000000, 10};
        vecs[4] = '{1'b0, 16'h0300, 4'd5,  32'h0, 14, 32'h00000001, 9, 1'b1, 32'h00000000, 15};
        vecs[5] = '{1'b1, 16'hABCD, 4'd9,  32'hCAFEF00D, 0, 32'h0, 0, 1'b0, 32'h0, 0};
        vecs[6] = '{1'b0, 16'h0044, 4'd1,  32'h0, 7,  32'h12345678, 8, 1'b0, 32'h12345678, 0};

        rst = 1'b1; core_req = 1'b0; core_wr = 1'b0; core_addr = '0; core_fid = '0;
        core_wdata = '0; io_ack = 1'b0; io_ack_data = '0;
        #12;
        check("rst_io_req", io_req, 0);
        check("rst_rvalid", core_rvalid, 0);
        check("rst_err", core_err, 0);
        check("rst_spur", spur_ack, 0);
        check("rst_io_cmd", 64'(io_cmd), 0);
        check("rst_rdata", core_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_rdy", core_rdy, 1);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].wr) run_write(vecs[i]);
            else            run_read(vecs[i]);
        end

        // Back-to-back writes with core_req held high.
        last_rdata = core_rdata;
        core_req = 1'b1; core_wr = 1'b1; core_addr = 16'h0777; core_fid = 4'd2; core_wdata = 32'h1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (io_req) req_at.push_back(i);
            if (req_at.size() >= 2) core_req = 1'b0;
        end
        core_req = 1'b0;
        check("b2b_req_count", 64'(req_at.size()), 2);
        if (req_at.size() >= 2) check("b2b_req_spacing", 64'(req_at[1] - req_at[0]), 4);
        check("rdata_holds", core_rdata, last_rdata);

        // Reset asserted mid-WAIT aborts the read silently.
        accept(1'b0, 16'h0099, 4'd6, 32'h0);
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_io_req", io_req, 0);
        check("mid_rst_rvalid", core_rvalid, 0);
        check("mid_rst_err", core_err, 0);
        check("mid_rst_spur", spur_ack, 0);
        check("mid_rst_io_cmd", 64'(io_cmd), 0);
        check("mid_rst_rdata", core_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("mid_rst_rdy", core_rdy, 1);
        io_ack = 1'b1; io_ack_data = 32'h77;
        tick();
        io_ack = 1'b0;
        check("mid_rst_spur_pulse", spur_ack, 1);
        check("mid_rst_no_rvalid", core_rvalid, 0);
        tick();
        check("mid_rst_spur_clear", spur_ack, 0);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 24; k++) begin
            v.wr       = ($urandom_range(0, 3) == 0);
            v.addr     = 16'($urandom);
            v.fid      = 4'($urandom);
            v.wdata    = $urandom;
            v.delay    = $urandom_range(1, 12);
            v.ack_data = $urandom;
            v = model(v);
            if (v.wr) run_write(v);
            else      run_read(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
